fetch_pc_unit: RTL

Instruction-fetch stage of the single-cycle processor, directly upstream of the opcode control decoder. Holds the program counter and drives the instruction-memory address. Resolves the next PC from the decoder's jump/branch/jal strobes and the ALU compare flags, and provides the jal link value. Holds the PC while the multi-cycle multdiv unit stalls the pipeline, and counts committed instructions.

---
 rtl/fetch_pc_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - instruction-fetch PC register, next-PC resolution and commit counter
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               jp_ctrl,
    input  logic               jal_ctrl,
    input  logic               jr_ctrl,
    input  logic               bne_ctrl,
    input  logic               blt_ctrl,
    input  logic               is_not_equal,
    input  logic               is_less_than,
    input  logic [26:0]        target,
    input  logic [16:0]        imm,
    input  logic [31:0]        rd_value,
    input  logic               stall,
    output logic [31:0]        pc,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc_plus1,
    output logic               link_we,
    output logic               fetch_valid,
    output logic [31:0]        instr_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] imm_ext;
    logic [31:0] branch_target;
    logic        take_branch;
    logic [31:0] pc_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // BOOT spends one cycle covering the synchronous imem read latency.
    always_comb begin
        state_next  = state;
        fetch_valid = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                fetch_valid = ~stall;
                if (stall) state_next = STALL;
            end
            STALL: begin
                fetch_valid = ~stall;
                if (!stall) state_next = RUN;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign pc_plus1      = pc + 32'd1;
    assign imem_addr     = pc[IMEM_AW-1:0];
    assign imm_ext       = {{15{imm[16]}}, imm};
    assign branch_target = pc_plus1 + imm_ext;
    assign take_branch   = (bne_ctrl & is_not_equal) | (blt_ctrl & is_less_than);
    assign link_we       = jal_ctrl & fetch_valid;

    // Fixed priority makes simultaneous decoder strobes resolve deterministically.
    always_comb begin
        pc_next = pc_plus1;
        if (jr_ctrl) begin
            pc_next = rd_value;
        end else if (jp_ctrl) begin
            pc_next = {5'b0, target};
        end else if (take_branch) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_count <= 32'd0;
        end else if (fetch_valid) begin
            pc          <= pc_next;
            instr_count <= instr_count + 32'd1;
        end
    end

endmodule
